// File: rtl/psum_ofifo_pkg.sv
// Shared parameters for the MAC-array output path: default array geometry and
// pointer width derived from the per-lane FIFO depth.
package psum_ofifo_pkg;

    localparam int unsigned COL_DEFAULT     = 8;
    localparam int unsigned PSUM_BW_DEFAULT = 16;
    localparam int unsigned DEPTH_DEFAULT   = 16;
    localparam int unsigned PTR_W_DEFAULT   = $clog2(DEPTH_DEFAULT);

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned d);
        return (d < 2) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// One column lane of the output FIFO: circular buffer with write/read
// pointers and an occupancy count that separates full from empty.
module psum_col_fifo
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW_DEFAULT,
    parameter int unsigned depth   = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int unsigned ptr_w = ptr_width(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [ptr_w-1:0]   wptr;
    logic [ptr_w-1:0]   rptr;
    logic [ptr_w:0]     count;
    logic               push;
    logic               pop;

    assign full  = (count == (ptr_w + 1)'(depth));
    assign empty = (count == '0);

    // A full lane still takes a write when a pop frees the head slot this cycle.
    assign push = wr && (!full || rd);
    assign pop  = rd && !empty;

    // Head entry is presented combinationally; the top registers it on a pop.
    assign dout = mem[rptr];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wptr] <= din;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + ptr_w'(1);
            if (pop)  rptr <= rptr + ptr_w'(1);
            case ({push, pop})
                2'b10:   count <= count + (ptr_w + 1)'(1);
                2'b01:   count <= count - (ptr_w + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO for the MAC array: one independent lane per column absorbs the
// skewed south outputs; whole rows are popped once every lane holds data.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned col     = COL_DEFAULT,
    parameter int unsigned psum_bw = PSUM_BW_DEFAULT,
    parameter int unsigned depth   = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_overflow
);

    logic [col-1:0]         full_vec;
    logic [col-1:0]         empty_vec;
    logic [psum_bw*col-1:0] head_row;
    logic                   pop;
    logic [col-1:0]         drop_vec;

    assign o_ready = &(~empty_vec);
    assign o_full  = |full_vec;
    assign o_empty = &empty_vec;

    assign pop      = rd && o_ready;
    assign drop_vec = wr & full_vec & {col{~pop}};

    for (genvar c = 0; c < col; c++) begin : g_lane
        psum_col_fifo #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[c]),
            .rd    (pop),
            .din   (in[psum_bw*c +: psum_bw]),
            .dout  (head_row[psum_bw*c +: psum_bw]),
            .full  (full_vec[c]),
            .empty (empty_vec[c])
        );
    end

    // Registered output row and one-cycle valid pulse per accepted pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            out     <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= pop;
            if (pop) out <= head_row;
        end
    end

    // Sticky record of any write dropped against a full lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_overflow <= 1'b0;
        end else if (|drop_vec) begin
            o_overflow <= 1'b1;
        end
    end

endmodule
